// File: rtl/ulbf_slave_capture_mc.sv
// Multi-channel AXI4-Stream capture slave: NCH independent streams framed into per-channel RAMs,
// with sticky framing/keep/overflow flags and a pipelined random-access readback port.

module ulbf_cap_lane #(
  parameter int TDATA_WIDTH = 64,
  parameter int TKEEP_WIDTH = TDATA_WIDTH/8,
  parameter int RAM_DEPTH   = 1536,
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_AW      = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   cap,
  input  logic                   mode,
  input  logic [11:0]            niter,
  input  logic [ADDR_WIDTH-1:0]  frame_len,
  input  logic                   tvalid,
  input  logic                   tlast,
  input  logic [TDATA_WIDTH-1:0] tdata,
  input  logic [TKEEP_WIDTH-1:0] tkeep,
  output logic                   tready,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  counter,
  output logic                   err_tlast,
  output logic                   err_tkeep,
  output logic                   err_ovf,
  input  logic                   rd_sel,
  input  logic [RAM_AW-1:0]      rd_idx,
  output logic [TDATA_WIDTH-1:0] rdata
);
  logic [TDATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr, beat;
  logic [11:0]            iter;
  logic                   acc;

  assign tready = cap & ~done;
  assign acc    = tvalid & tready;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr    <= '0;
      beat      <= '0;
      iter      <= '0;
      counter   <= '0;
      err_tlast <= 1'b0;
      err_tkeep <= 1'b0;
      err_ovf   <= 1'b0;
      done      <= 1'b0;
    end else if (acc) begin
      if (counter != '1) counter <= counter + 1'b1;
      if (~&tkeep) err_tkeep <= 1'b1;
      // framing is driven by frame_len alone; tlast is only checked against it
      if (beat == frame_len - 1'b1) begin
        beat <= '0;
        iter <= iter + 1'b1;
        if (!tlast) err_tlast <= 1'b1;
        if (iter + 1'b1 == niter) done <= 1'b1;
      end else begin
        beat <= beat + 1'b1;
        if (tlast) err_tlast <= 1'b1;
      end
      if (wr_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
        wr_ptr <= '0;
        if (!mode) begin
          err_ovf <= 1'b1;
          done    <= 1'b1;
        end
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // read-first: the read picks up the pre-write word on an address collision
  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr[RAM_AW-1:0]] <= tdata;
    if (rd_sel) rdata <= mem[rd_idx];
  end
endmodule

module ulbf_slave_capture_mc #(
  parameter int NCH         = 4,
  parameter int TDATA_WIDTH = 64,
  parameter int TKEEP_WIDTH = TDATA_WIDTH/8,
  parameter int RAM_DEPTH   = 1536,
  parameter int ADDR_WIDTH  = 16,
  parameter int RD_LATENCY  = 2
) (
  input  logic                       s_axis_clk,
  input  logic                       slave_rst,
  input  logic [NCH-1:0]             s_axis_tvalid,
  output logic [NCH-1:0]             s_axis_tready,
  input  logic [NCH-1:0]             s_axis_tlast,
  input  logic [NCH*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NCH*TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mode,
  input  logic [11:0]                niter,
  input  logic [ADDR_WIDTH-1:0]      frame_len,
  output logic                       rxdone,
  output logic [3:0]                 current_state,
  output logic [NCH*ADDR_WIDTH-1:0]  rxram_counter,
  output logic [NCH-1:0]             err_tlast,
  output logic [NCH-1:0]             err_tkeep,
  output logic [NCH-1:0]             err_ovf,
  input  logic                       rd_en,
  input  logic [7:0]                 rd_ch,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic                       rd_valid,
  output logic [TDATA_WIDTH-1:0]     rd_data
);
  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [3:0] {IDLE = 4'd0, ARM = 4'd1, CAP = 4'd2, DONE = 4'd3} state_t;
  typedef struct packed {
    logic                  mode;
    logic [11:0]           niter;
    logic [ADDR_WIDTH-1:0] frame_len;
  } cfg_t;

  state_t                              state;
  cfg_t                                cfg;
  logic                                clr;
  logic [NCH-1:0]                      lane_done, rd_sel;
  logic [NCH-1:0][TDATA_WIDTH-1:0]     lane_rdata;
  logic                                rd_ok, rd_ok_q;
  logic [CHW-1:0]                      rd_ch_q;
  logic [TDATA_WIDTH-1:0]              rd_s1;
  logic [RD_LATENCY:1]                 vld_pipe;

  assign current_state = state;
  // counters and flags clear on the same edge that enters ARM
  assign clr = start & ~abort & ((state == IDLE) || (state == DONE));

  always_ff @(posedge s_axis_clk) begin
    if (slave_rst) begin
      state  <= IDLE;
      rxdone <= 1'b0;
      cfg    <= '0;
    end else if (abort) begin
      state  <= IDLE;
      rxdone <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state  <= ARM;
          rxdone <= 1'b0;
          cfg    <= '{mode: mode, niter: niter, frame_len: frame_len};
        end
        ARM: if (cfg.niter == '0 || cfg.frame_len == '0) begin
          state  <= DONE;
          rxdone <= 1'b1;
        end else begin
          state <= CAP;
        end
        CAP: if (&lane_done) begin
          state  <= DONE;
          rxdone <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_ok = (int'(rd_ch) < NCH) && (int'(rd_addr) < RAM_DEPTH);

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    assign rd_sel[c] = rd_en & rd_ok & (int'(rd_ch) == c);
    ulbf_cap_lane #(
      .TDATA_WIDTH(TDATA_WIDTH), .TKEEP_WIDTH(TKEEP_WIDTH), .RAM_DEPTH(RAM_DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH), .RAM_AW(RAM_AW)
    ) u_lane (
      .clk       (s_axis_clk),
      .rst       (slave_rst),
      .clr       (clr),
      .cap       (state == CAP),
      .mode      (cfg.mode),
      .niter     (cfg.niter),
      .frame_len (cfg.frame_len),
      .tvalid    (s_axis_tvalid[c]),
      .tlast     (s_axis_tlast[c]),
      .tdata     (s_axis_tdata[c*TDATA_WIDTH +: TDATA_WIDTH]),
      .tkeep     (s_axis_tkeep[c*TKEEP_WIDTH +: TKEEP_WIDTH]),
      .tready    (s_axis_tready[c]),
      .done      (lane_done[c]),
      .counter   (rxram_counter[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .err_tlast (err_tlast[c]),
      .err_tkeep (err_tkeep[c]),
      .err_ovf   (err_ovf[c]),
      .rd_sel    (rd_sel[c]),
      .rd_idx    (rd_addr[RAM_AW-1:0]),
      .rdata     (lane_rdata[c])
    );
  end

  // RAM read is stage 1; the channel mux sits after it, extra stages follow
  always_ff @(posedge s_axis_clk) begin
    if (slave_rst) begin
      rd_ok_q  <= 1'b0;
      rd_ch_q  <= '0;
      vld_pipe <= '0;
    end else begin
      rd_ok_q     <= rd_en & rd_ok;
      rd_ch_q     <= rd_ch[CHW-1:0];
      vld_pipe[1] <= rd_en;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign rd_s1    = rd_ok_q ? lane_rdata[rd_ch_q] : '0;
  assign rd_valid = vld_pipe[RD_LATENCY];

  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data = rd_s1;
  end else begin : g_latn
    logic [RD_LATENCY:2][TDATA_WIDTH-1:0] dpipe;
    always_ff @(posedge s_axis_clk) begin
      if (slave_rst) begin
        dpipe <= '0;
      end else begin
        dpipe[2] <= rd_s1;
        for (int i = 3; i <= RD_LATENCY; i++) dpipe[i] <= dpipe[i-1];
      end
    end
    assign rd_data = dpipe[RD_LATENCY];
  end
endmodule

// File: tb/tb_ulbf_slave_capture_mc.sv
// Randomized bench for ulbf_slave_capture_mc against a frame/RAM-level reference model.
`timescale 1ns/1ps
module tb_ulbf_slave_capture_mc;
  localparam int NCH = 4, DW = 64, KW = DW/8, DEPTH = 16, AW = 16, RDL = 2, MAXB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, mode, rxdone, rd_en, rd_valid;
  logic [NCH-1:0] tvalid, tready, tlast, e_l, e_k, e_o;
  logic [NCH*DW-1:0] tdata;
  logic [NCH*KW-1:0] tkeep;
  logic [11:0] niter;
  logic [AW-1:0] frame_len, rd_addr;
  logic [3:0] cur;
  logic [NCH*AW-1:0] cnt;
  logic [7:0] rd_ch;
  logic [DW-1:0] rd_data;

  logic tv [NCH];
  logic tl [NCH];
  logic [DW-1:0] td [NCH];
  logic [KW-1:0] tk [NCH];
  for (genvar g = 0; g < NCH; g++) begin : g_pk
    assign tvalid[g] = tv[g];
    assign tlast[g] = tl[g];
    assign tdata[g*DW +: DW] = td[g];
    assign tkeep[g*KW +: KW] = tk[g];
  end

  int nchk = 0, nfail = 0;
  logic [DW-1:0] sd [NCH][MAXB];
  logic          sl [NCH][MAXB];
  logic [KW-1:0] sk [NCH][MAXB];
  int duty [NCH], hold [NCH], nbeat [NCH], last_acc [NCH];
  bit fin [NCH];

  ulbf_slave_capture_mc #(.NCH(NCH), .TDATA_WIDTH(DW), .TKEEP_WIDTH(KW), .RAM_DEPTH(DEPTH),
                          .ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
    .s_axis_clk(clk), .slave_rst(rst), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tlast(tlast), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .start(start),
    .abort(abort), .mode(mode), .niter(niter), .frame_len(frame_len), .rxdone(rxdone),
    .current_state(cur), .rxram_counter(cnt), .err_tlast(e_l), .err_tkeep(e_k), .err_ovf(e_o),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  // Beats accepted: the whole capture, or up to a full RAM when stopping on full.
  function automatic int exp_acc(int ni, int fl, bit md);
    int n = ni * fl;
    if (!md && n >= DEPTH) return DEPTH;
    return n;
  endfunction

  // Latest beat that landed on address a (address = beat index modulo depth).
  function automatic logic [DW-1:0] exp_mem(int c, int a);
    int k = a + DEPTH * ((last_acc[c] - 1 - a) / DEPTH);
    return sd[c][k];
  endfunction

  task automatic gen_stim(input int ni, input int fl);
    for (int c = 0; c < NCH; c++) begin
      duty[c] = 100; hold[c] = -1;
      for (int k = 0; k < MAXB; k++) begin
        sd[c][k] = {8'(c), 8'(k), 16'($urandom), 32'($urandom)};
        sl[c][k] = (fl > 0) ? ((k % fl) == fl - 1) : 1'b0;
        sk[c][k] = '1;
      end
    end
    if (ni * fl > MAXB) $fatal(1, "FAIL stim_size: %0d beats exceeds %0d", ni * fl, MAXB);
  endtask

  task automatic drive(input int c);
    int k = 0, cyc = 0;
    if (hold[c] >= 0) begin
      while (!fin[hold[c]] && cyc < 4000) begin @(negedge clk); cyc++; end
      nchk++;
      if (cur !== 4'd2 || rxdone !== 1'b0) begin
        nfail++;
        $display("FAIL hold_ch%0d: state=%0d rxdone=%0b, want state=2 rxdone=0", c, cur, rxdone);
      end
      cyc = 0;
    end
    while (k < nbeat[c] && cyc < 4000) begin
      @(negedge clk); cyc++;
      if ($urandom_range(99) < duty[c]) begin
        tv[c] = 1'b1; td[c] = sd[c][k]; tl[c] = sl[c][k]; tk[c] = sk[c][k];
        if (tready[c]) k++;
      end else begin
        tv[c] = 1'b0; tl[c] = 1'b0;
      end
    end
    @(negedge clk); tv[c] = 1'b0; tl[c] = 1'b0;
    nchk++;
    if (k != nbeat[c]) begin
      nfail++;
      $display("FAIL drive_ch%0d: accepted %0d beats, want %0d", c, k, nbeat[c]);
    end
    fin[c] = 1'b1;
  endtask

  task automatic do_start(input int ni, input int fl, input bit md);
    @(negedge clk); niter = 12'(ni); frame_len = AW'(fl); mode = md; start = 1'b1;
    @(negedge clk); start = 1'b0;
    nchk++;
    if (cur !== 4'd1 || cnt !== '0 || rxdone !== 1'b0 || e_l !== '0 || e_k !== '0 ||
        e_o !== '0 || tready !== '0) begin
      nfail++;
      $display("FAIL arm: state=%0d cnt=%h rxdone=%0b err=%b/%b/%b tready=%b, want 1/0/0/0/0", cur,
               cnt, rxdone, e_l, e_k, e_o, tready);
    end
  endtask

  task automatic rd_check(input int c, input int a, input logic [DW-1:0] exp, input string nm);
    @(negedge clk); rd_en = 1'b1; rd_ch = 8'(c); rd_addr = AW'(a);
    @(negedge clk); rd_en = 1'b0;
    nchk++;
    if (rd_valid !== 1'b0) begin
      nfail++; $display("FAIL %s rd_early ch%0d a%0d: rd_valid=%b, want 0", nm, c, a, rd_valid);
    end
    @(negedge clk);
    nchk++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      nfail++;
      $display("FAIL %s rd ch%0d a%0d: valid=%b data=%h, want 1 %h", nm, c, a, rd_valid, rd_data, exp);
    end
  endtask

  task automatic run_capture(input string nm, input int ni, input int fl, input bit md);
    int cyc, acc;
    bit el, ek, eo;
    for (int c = 0; c < NCH; c++) begin
      last_acc[c] = exp_acc(ni, fl, md); nbeat[c] = last_acc[c]; fin[c] = 1'b0;
    end
    do_start(ni, fl, md);
    fork drive(0); drive(1); drive(2); drive(3); join
    cyc = 0;
    while (rxdone !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    nchk++;
    if (rxdone !== 1'b1 || cur !== 4'd3) begin
      nfail++; $display("FAIL %s done: rxdone=%b state=%0d, want 1 3", nm, rxdone, cur);
    end
    for (int c = 0; c < NCH; c++) begin
      acc = last_acc[c]; el = 0; ek = 0;
      for (int k = 0; k < acc; k++) begin
        if (sl[c][k] != ((k % fl) == fl - 1)) el = 1;
        if (sk[c][k] != '1) ek = 1;
      end
      eo = !md && (ni * fl >= DEPTH);
      nchk++;
      if (cnt[c*AW +: AW] !== AW'(acc) || e_l[c] !== el || e_k[c] !== ek || e_o[c] !== eo ||
          tready[c] !== 1'b0) begin
        nfail++;
        $display("FAIL %s ch%0d status: cnt=%0d tl=%b tk=%b ovf=%b rdy=%b, want %0d %b %b %b 0",
                 nm, c, cnt[c*AW +: AW], e_l[c], e_k[c], e_o[c], tready[c], acc, el, ek, eo);
      end
      for (int a = 0; a < acc && a < DEPTH; a++) rd_check(c, a, exp_mem(c, a), nm);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; abort = 0; mode = 0; niter = 0; frame_len = 0;
    rd_en = 0; rd_ch = 0; rd_addr = 0;
    for (int c = 0; c < NCH; c++) begin tv[c] = 0; tl[c] = 0; td[c] = '0; tk[c] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nchk++;
    if (cur !== 4'd0 || rxdone !== 1'b0 || tready !== '0) begin
      nfail++; $display("FAIL reset_ctl: state=%0d rxdone=%b tready=%b, want 0 0 0", cur, rxdone, tready);
    end
    nchk++;
    if (cnt !== '0 || e_l !== '0 || e_k !== '0 || e_o !== '0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      nfail++;
      $display("FAIL reset_stat: cnt=%h err=%b/%b/%b rdv=%b rdd=%h, want all 0", cnt, e_l, e_k, e_o,
               rd_valid, rd_data);
    end
  endtask

  task automatic test_basic;
    gen_stim(2, 8);
    run_capture("basic", 2, 8, 1'b1);
    rd_check(2, 5, sd[2][5], "basic_ch2a5");
  endtask

  task automatic test_tlast;
    gen_stim(2, 8);
    sl[1][3] = 1'b1;
    run_capture("tlast", 2, 8, 1'b1);
  endtask

  task automatic test_ovf;
    gen_stim(2, 10);
    run_capture("ovf_m0", 2, 10, 1'b0);
    gen_stim(2, 10);
    run_capture("wrap_m1", 2, 10, 1'b1);
  endtask

  task automatic test_backpressure;
    gen_stim(2, 8);
    duty[0] = 30; duty[1] = 70; hold[3] = 0;
    run_capture("bp", 2, 8, 1'b1);
  endtask

  task automatic test_abort;
    gen_stim(2, 8);
    for (int c = 0; c < NCH; c++) begin nbeat[c] = 5; fin[c] = 1'b0; end
    do_start(2, 8, 1'b1);
    fork drive(0); drive(1); drive(2); drive(3); join
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    nchk++;
    if (cur !== 4'd0 || rxdone !== 1'b0 || tready !== '0) begin
      nfail++; $display("FAIL abort_ctl: state=%0d rxdone=%b tready=%b, want 0 0 0", cur, rxdone, tready);
    end
    for (int c = 0; c < NCH; c++) begin
      nchk++;
      if (cnt[c*AW +: AW] !== AW'(5)) begin
        nfail++; $display("FAIL abort_hold ch%0d: cnt=%0d, want 5", c, cnt[c*AW +: AW]);
      end
    end
    gen_stim(2, 8);
    run_capture("restart", 2, 8, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] e0, e1;
    e0 = exp_mem(0, 1); e1 = exp_mem(1, 2);
    @(negedge clk); rd_en = 1'b1; rd_ch = 8'd0; rd_addr = AW'(1);
    @(negedge clk); rd_ch = 8'd1; rd_addr = AW'(2);
    @(negedge clk); rd_ch = 8'd5; rd_addr = AW'(0);
    nchk++;
    if (rd_valid !== 1'b1 || rd_data !== e0) begin
      nfail++; $display("FAIL b2b_0: valid=%b data=%h, want 1 %h", rd_valid, rd_data, e0);
    end
    @(negedge clk); rd_en = 1'b0;
    nchk++;
    if (rd_valid !== 1'b1 || rd_data !== e1) begin
      nfail++; $display("FAIL b2b_1: valid=%b data=%h, want 1 %h", rd_valid, rd_data, e1);
    end
    @(negedge clk);
    nchk++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      nfail++; $display("FAIL b2b_badch: valid=%b data=%h, want 1 0", rd_valid, rd_data);
    end
    @(negedge clk);
    nchk++;
    if (rd_valid !== 1'b0) begin
      nfail++; $display("FAIL b2b_end: valid=%b, want 0", rd_valid);
    end
  endtask

  task automatic test_zero;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) do_start(0, 8, 1'b0); else do_start(2, 0, 1'b0);
      @(negedge clk);
      nchk++;
      if (cur !== 4'd3 || rxdone !== 1'b1 || tready !== '0 || cnt !== '0) begin
        nfail++;
        $display("FAIL zero_p%0d: state=%0d rxdone=%b tready=%b cnt=%h, want 3 1 0 0", pass, cur,
                 rxdone, tready, cnt);
      end
    end
    rd_check(0, DEPTH, '0, "zero_oob_addr");
    rd_check(NCH, 0, '0, "zero_oob_ch");
  endtask

  task automatic test_random;
    int ni, fl, ch;
    bit md;
    for (int it = 0; it < 5; it++) begin
      ni = $urandom_range(1, 3); fl = $urandom_range(1, 10); md = 1'($urandom_range(0, 1));
      gen_stim(ni, fl);
      for (int c = 0; c < NCH; c++) duty[c] = $urandom_range(40, 100);
      ch = $urandom_range(0, NCH - 1);
      sl[ch][$urandom_range(0, ni * fl - 1)] ^= 1'b1;
      if ($urandom_range(0, 1) == 1) sk[$urandom_range(0, NCH - 1)][$urandom_range(0, ni * fl - 1)] = 8'h7f;
      run_capture($sformatf("rand%0d", it), ni, fl, md);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_tlast();
    test_ovf();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
